addr_gen_upd_seq: RTL and testbench

- Write address sequencer for the update-parameter stage.
- Replaces the fixed-length, fixed-delay per-instance generators with one runtime-configurable block.
- Mode select per pass: dW, dU, db or per-timestep buffer, each with its own region base and length.
- Programmable beat delay, start/busy/done handshake, pause (en), synchronous abort, and a one-cycle write strobe per address.

---
 rtl/addr_gen_upd_seq.sv | 160 ++++++++++++++++
 tb/tb_addr_gen_upd_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/addr_gen_upd_seq.sv
// Write address sequencer for the update-parameter stage: one runtime-selected
// region (dW, dU, db or per-timestep buffer) is walked at a programmable beat rate.
module addr_gen_upd_seq #(
   parameter int ADDR_WIDTH = 12,
   parameter int DLY_WIDTH  = 4,
   parameter int NUM_CELL   = 8,
   parameter int NUM_INPUT  = 53,
   parameter int TIMESTEP   = 7,
   parameter int BASE_W     = 0,
   parameter int BASE_U     = 424,
   parameter int BASE_B     = 488,
   parameter int BASE_T     = 496
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  i_start,
   input  logic                  i_clear,
   input  logic [1:0]            i_mode,
   input  logic [DLY_WIDTH-1:0]  i_delay,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_valid,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int LEN_W = NUM_CELL * NUM_INPUT;
   localparam int LEN_U = NUM_CELL * NUM_CELL;
   localparam int LEN_B = NUM_CELL;
   localparam int LEN_T = NUM_CELL * TIMESTEP;

   function automatic logic [ADDR_WIDTH-1:0] f_base(input logic [1:0] mode);
      logic [ADDR_WIDTH-1:0] base;
      case (mode)
         2'd0:    base = ADDR_WIDTH'(BASE_W);
         2'd1:    base = ADDR_WIDTH'(BASE_U);
         2'd2:    base = ADDR_WIDTH'(BASE_B);
         default: base = ADDR_WIDTH'(BASE_T);
      endcase
      return base;
   endfunction

   // Last valid index of each region, so the end test needs no subtractor.
   function automatic logic [ADDR_WIDTH-1:0] f_last(input logic [1:0] mode);
      logic [ADDR_WIDTH-1:0] last;
      case (mode)
         2'd0:    last = ADDR_WIDTH'(LEN_W - 1);
         2'd1:    last = ADDR_WIDTH'(LEN_U - 1);
         2'd2:    last = ADDR_WIDTH'(LEN_B - 1);
         default: last = ADDR_WIDTH'(LEN_T - 1);
      endcase
      return last;
   endfunction

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_index;
   logic [DLY_WIDTH-1:0]  r_beat;
   logic [1:0]            r_mode;
   logic [DLY_WIDTH-1:0]  r_delay;
   logic [ADDR_WIDTH-1:0] r_addr;

   logic [1:0]            w_state_next;
   logic [ADDR_WIDTH-1:0] w_index_next;
   logic [DLY_WIDTH-1:0]  w_beat_next;
   logic [1:0]            w_mode_next;
   logic [DLY_WIDTH-1:0]  w_delay_next;
   logic [ADDR_WIDTH-1:0] w_addr_next;

   logic [DLY_WIDTH-1:0]  w_delay_in;
   logic [ADDR_WIDTH-1:0] w_index_inc;
   logic                  w_last_beat;
   logic                  w_last_index;
   logic                  w_step;

   // A zero delay would never produce a beat, so it is promoted to one.
   assign w_delay_in   = (i_delay == '0) ? DLY_WIDTH'(1) : i_delay;
   assign w_index_inc  = r_index + ADDR_WIDTH'(1);
   assign w_last_beat  = (r_beat == (r_delay - DLY_WIDTH'(1)));
   assign w_last_index = (r_index == f_last(r_mode));
   assign w_step       = (r_state == S_RUN) && en && w_last_beat && !i_clear;

   assign o_valid = w_step;
   assign o_busy  = (r_state == S_RUN);
   assign o_done  = (r_state == S_DONE) && !i_clear;
   assign o_addr  = r_addr;

   always_comb begin
      w_state_next = r_state;
      w_index_next = r_index;
      w_beat_next  = r_beat;
      w_mode_next  = r_mode;
      w_delay_next = r_delay;
      w_addr_next  = r_addr;
      if (i_clear) begin
         // Abort wins over start and over a final beat; o_addr keeps its value.
         w_state_next = S_IDLE;
         w_index_next = '0;
         w_beat_next  = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  w_mode_next  = i_mode;
                  w_delay_next = w_delay_in;
                  w_index_next = '0;
                  w_beat_next  = '0;
                  w_addr_next  = f_base(i_mode);
                  w_state_next = S_RUN;
               end
            end
            S_RUN: begin
               if (en) begin
                  if (w_last_beat) begin
                     w_beat_next = '0;
                     if (w_last_index) begin
                        w_state_next = S_DONE;
                     end else begin
                        w_index_next = w_index_inc;
                        w_addr_next  = f_base(r_mode) + w_index_inc;
                     end
                  end else begin
                     w_beat_next = r_beat + DLY_WIDTH'(1);
                  end
               end
            end
            S_DONE: begin
               w_state_next = S_IDLE;
            end
            default: begin
               w_state_next = S_IDLE;
               w_index_next = '0;
               w_beat_next  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_index <= '0;
         r_beat  <= '0;
         r_mode  <= '0;
         r_delay <= '0;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_next;
         r_index <= w_index_next;
         r_beat  <= w_beat_next;
         r_mode  <= w_mode_next;
         r_delay <= w_delay_next;
         r_addr  <= w_addr_next;
      end
   end

endmodule

// File: tb/tb_addr_gen_upd_seq.sv
// Scoreboard bench for addr_gen_upd_seq: directed passes push expected strobes
// and done pulses; a negedge monitor pops and compares them.
module tb_addr_gen_upd_seq;

   logic        clk;
   logic        rst;
   logic        en;
   logic        i_start;
   logic        i_clear;
   logic [1:0]  i_mode;
   logic [3:0]  i_delay;
   logic [11:0] o_addr;
   logic        o_valid;
   logic        o_busy;
   logic        o_done;

   addr_gen_upd_seq dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .i_start (i_start),
      .i_clear (i_clear),
      .i_mode  (i_mode),
      .i_delay (i_delay),
      .o_addr  (o_addr),
      .o_valid (o_valid),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   typedef struct {
      bit is_done;
      int addr;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec      = 0;
   int   n_err      = 0;
   int   n_strobe   = 0;
   int   done_total = 0;
   int   busy_total = 0;
   int   en_cnt     = 0;
   int   exp_d      = 1;

   int base_tab[4] = '{0, 424, 488, 496};
   int len_tab[4]  = '{424, 64, 8, 56};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic pop_cmp(input bit is_done, input int addr);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL unexpected_%s: got addr %0d, expected no event",
                  is_done ? "done" : "strobe", addr);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", is_done, e.is_done);
         check("event_addr", addr, e.addr);
      end
   endtask

   always @(negedge clk) begin
      if (o_busy === 1'b1 && en) en_cnt++;
      if (o_busy === 1'b1) busy_total++;
      if (o_valid === 1'b1) begin
         n_strobe++;
         check("strobe_en", en, 1);
         check("strobe_spacing", en_cnt, exp_d);
         en_cnt = 0;
         pop_cmp(1'b0, int'(o_addr));
      end
      if (o_done === 1'b1) begin
         done_total++;
         check("done_busy", o_busy, 0);
         pop_cmp(1'b1, int'(o_addr));
      end
      if (o_busy !== 1'b1) en_cnt = 0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pass(input int mode, input int count, input bit with_done);
      for (int k = 0; k < count; k++) exp_q.push_back('{1'b0, base_tab[mode] + k});
      if (with_done) exp_q.push_back('{1'b1, base_tab[mode] + count - 1});
   endtask

   // One full pass; restart_at re-pulses i_start mid-run, exp_run < 0 skips the cycle count.
   task automatic run_pass(input int mode, input int delay, input bit toggle,
                           input int restart_at, input int exp_run);
      int b0;
      int d0;
      exp_d = (delay == 0) ? 1 : delay;
      push_pass(mode, len_tab[mode], 1'b1);
      b0 = busy_total;
      d0 = done_total;
      en      = 1'b1;
      i_mode  = 2'(mode);
      i_delay = 4'(delay);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      i_mode  = 2'(mode + 1);
      i_delay = 4'd5;
      for (int i = 0; i < 2000; i++) begin
         if (toggle) en = ~en;
         i_start = (i == restart_at);
         tick();
         if (done_total != d0) break;
      end
      i_start = 1'b0;
      en      = 1'b1;
      tick();
      tick();
      tick();
      check("done_count", done_total - d0, 1);
      check("busy_after", o_busy, 0);
      check("queue_drained", exp_q.size(), 0);
      if (exp_run >= 0) check("run_cycles", busy_total - b0, exp_run);
   endtask

   initial begin
      int s0;
      int d0;
      rst     = 1'b1;
      en      = 1'b1;
      i_start = 1'b0;
      i_clear = 1'b0;
      i_mode  = 2'd0;
      i_delay = 4'd0;
      #3 rst = 1'b0;
      tick();
      tick();
      check("rst_addr", o_addr, 0);
      check("rst_valid", o_valid, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      rst = 1'b1;
      tick();

      run_pass(2, 1, 1'b0, -1, 8);
      run_pass(3, 7, 1'b0, -1, 392);
      run_pass(1, 3, 1'b1, -1, -1);
      run_pass(0, 0, 1'b0, 200, 424);

      // Abort mode 0 at index 100 with a simultaneous start.
      exp_d = 1;
      push_pass(0, 100, 1'b0);
      s0 = n_strobe;
      d0 = done_total;
      i_mode  = 2'd0;
      i_delay = 4'd1;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int i = 0; i < 500; i++) begin
         tick();
         if (n_strobe - s0 == 100) break;
      end
      check("clr_pre_addr", o_addr, 100);
      check("clr_pre_busy", o_busy, 1);
      i_clear = 1'b1;
      i_start = 1'b1;
      i_mode  = 2'd2;
      tick();
      i_clear = 1'b0;
      i_start = 1'b0;
      check("clr_busy", o_busy, 0);
      check("clr_addr_hold", o_addr, 100);
      for (int i = 0; i < 5; i++) tick();
      check("clr_no_done", done_total - d0, 0);
      check("clr_still_idle", o_busy, 0);
      check("clr_queue", exp_q.size(), 0);
      run_pass(2, 1, 1'b0, -1, 8);

      // Asynchronous reset between edges, after three strobes of a mode 3 pass.
      exp_d = 7;
      push_pass(3, 3, 1'b0);
      s0 = n_strobe;
      d0 = done_total;
      i_mode  = 2'd3;
      i_delay = 4'd7;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (n_strobe - s0 == 3) break;
      end
      tick();
      tick();
      #3 rst = 1'b0;
      #1;
      check("arst_addr", o_addr, 0);
      check("arst_valid", o_valid, 0);
      check("arst_busy", o_busy, 0);
      check("arst_done", o_done, 0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check("arst_idle_busy", o_busy, 0);
      check("arst_idle_addr", o_addr, 0);
      check("arst_no_done", done_total - d0, 0);
      check("arst_queue", exp_q.size(), 0);
      run_pass(2, 2, 1'b0, -1, 16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
